// File: rtl/matmul_energy_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : matmul_energy_scheduler
// Brief    : Sequences one Ising energy evaluation per candidate spin vector,
//            with early abort and best-result tracking.
// Revision : 1.0 - initial release
// ============================================================================
module matmul_energy_scheduler #(
    parameter int VECTOR_SIZE     = 256,
    parameter int J_ELEMENT_WIDTH = 4,
    parameter int J_COLS_PER_READ = 4,
    parameter int NUM_J_CHUNKS    = VECTOR_SIZE / J_COLS_PER_READ,
    parameter int ENERGY_WIDTH    = 2 * $clog2(VECTOR_SIZE) + J_ELEMENT_WIDTH,
    parameter int ADDR_WIDTH      = 16,
    parameter int BASE_ADDR       = 0,
    parameter int CHUNK_STRIDE    = 1,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cand_valid,
    output logic                           cand_ready,
    input  logic [VECTOR_SIZE-1:0]         cand_sigma,
    output logic                           mem_req,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    input  logic                           mem_gnt,
    output logic [VECTOR_SIZE-1:0]         dp_sigma,
    input  logic signed [ENERGY_WIDTH-1:0] dp_partial,
    input  logic                           dp_partial_valid,
    input  logic                           abort_en,
    input  logic                           clear_best,
    output logic                           res_valid,
    output logic                           res_accept,
    output logic                           res_aborted,
    output logic signed [ENERGY_WIDTH-1:0] res_energy,
    output logic                           best_valid,
    output logic signed [ENERGY_WIDTH-1:0] best_energy,
    output logic [VECTOR_SIZE-1:0]         best_sigma,
    output logic                           err_unexpected
);

    localparam int CNT_W = $clog2(NUM_J_CHUNKS + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] c_num_chunks = CNT_W'(NUM_J_CHUNKS);
    localparam logic [OUT_W-1:0] c_max_out    = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic [VECTOR_SIZE-1:0]          r_sigma;
    logic [VECTOR_SIZE-1:0]          r_best_sigma;
    logic signed [ENERGY_WIDTH-1:0]  r_acc;
    logic signed [ENERGY_WIDTH-1:0]  w_acc_next;
    logic signed [ENERGY_WIDTH-1:0]  r_best_energy;
    logic [CNT_W-1:0]                r_issue_cnt;
    logic [OUT_W-1:0]                r_outstanding;
    logic [OUT_W-1:0]                w_out_next;
    logic                            r_aborted;
    logic                            r_best_valid;
    logic                            r_err;
    logic                            w_start;
    logic                            w_req;
    logic                            w_issue;
    logic                            w_ret;
    logic                            w_unexp;
    logic                            w_last_ret;
    logic                            w_abort;
    logic                            w_accept;

    always_comb begin
        w_start    = (r_state == ST_IDLE) && cand_valid;
        w_req      = (r_state == ST_FETCH) && (r_issue_cnt < c_num_chunks) &&
                     (r_outstanding < c_max_out) && !r_aborted;
        w_issue    = w_req && mem_gnt;
        w_ret      = dp_partial_valid && (r_outstanding != '0);
        w_unexp    = dp_partial_valid && (r_outstanding == '0);
        w_acc_next = (w_ret && !r_aborted) ? (r_acc + dp_partial) : r_acc;

        w_out_next = r_outstanding;
        case ({w_issue, w_ret})
            2'b10:   w_out_next = r_outstanding + OUT_W'(1);
            2'b01:   w_out_next = r_outstanding - OUT_W'(1);
            default: w_out_next = r_outstanding;
        endcase

        // The final chunk's return is never an abort point; DONE judges it.
        w_last_ret = w_ret && (r_issue_cnt == c_num_chunks) && (r_outstanding == OUT_W'(1));
        w_abort    = (r_state == ST_FETCH) && w_ret && !w_last_ret && abort_en &&
                     r_best_valid && (w_acc_next >= r_best_energy);
        w_accept   = (r_state == ST_DONE) && !r_aborted &&
                     (!r_best_valid || (r_acc < r_best_energy));
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cand_valid) w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (w_abort)
                    w_state_next = ST_DRAIN;
                else if ((r_issue_cnt == c_num_chunks) && (w_out_next == '0))
                    w_state_next = ST_DONE;
            end
            ST_DRAIN: begin
                if (w_out_next == '0) w_state_next = ST_DONE;
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_sigma       <= '0;
            r_acc         <= '0;
            r_issue_cnt   <= '0;
            r_outstanding <= '0;
            r_aborted     <= 1'b0;
            r_best_valid  <= 1'b0;
            r_best_energy <= '0;
            r_best_sigma  <= '0;
            r_err         <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_unexp) r_err <= 1'b1;

            if (w_start) begin
                r_sigma       <= cand_sigma;
                r_acc         <= '0;
                r_issue_cnt   <= '0;
                r_outstanding <= '0;
                r_aborted     <= 1'b0;
            end else begin
                r_acc         <= w_acc_next;
                r_outstanding <= w_out_next;
                if (w_issue) r_issue_cnt <= r_issue_cnt + CNT_W'(1);
                if (w_abort) r_aborted <= 1'b1;
            end

            // A same-cycle accept takes priority over clear_best.
            if (w_accept) begin
                r_best_energy <= r_acc;
                r_best_sigma  <= r_sigma;
                r_best_valid  <= 1'b1;
            end else if (clear_best) begin
                r_best_valid  <= 1'b0;
            end
        end
    end

    assign cand_ready     = (r_state == ST_IDLE);
    assign mem_req        = w_req;
    assign mem_addr       = ADDR_WIDTH'(BASE_ADDR) +
                            ADDR_WIDTH'(r_issue_cnt) * ADDR_WIDTH'(CHUNK_STRIDE);
    assign dp_sigma       = r_sigma;
    assign res_valid      = (r_state == ST_DONE);
    assign res_accept     = w_accept;
    assign res_aborted    = (r_state == ST_DONE) && r_aborted;
    assign res_energy     = (r_state == ST_DONE) ? r_acc : '0;
    assign best_valid     = r_best_valid;
    assign best_energy    = r_best_energy;
    assign best_sigma     = r_best_sigma;
    assign err_unexpected = r_err;

endmodule
`default_nettype wire

// File: tb/tb_matmul_energy_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_matmul_energy_scheduler
// Brief    : Scoreboard bench for matmul_energy_scheduler with a J-memory /
//            datapath responder model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matmul_energy_scheduler;

    localparam int VS = 256;
    localparam int EW = 20;
    localparam int AW = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 cand_valid = 1'b0;
    logic                 cand_ready;
    logic [VS-1:0]        cand_sigma = '0;
    logic                 mem_req;
    logic [AW-1:0]        mem_addr;
    logic                 mem_gnt;
    logic [VS-1:0]        dp_sigma;
    logic signed [EW-1:0] dp_partial;
    logic                 dp_partial_valid;
    logic                 abort_en = 1'b0;
    logic                 clear_best = 1'b0;
    logic                 res_valid;
    logic                 res_accept;
    logic                 res_aborted;
    logic signed [EW-1:0] res_energy;
    logic                 best_valid;
    logic signed [EW-1:0] best_energy;
    logic [VS-1:0]        best_sigma;
    logic                 err_unexpected;

    always #5 clk = ~clk;

    matmul_energy_scheduler dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cand_valid       (cand_valid),
        .cand_ready       (cand_ready),
        .cand_sigma       (cand_sigma),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_gnt          (mem_gnt),
        .dp_sigma         (dp_sigma),
        .dp_partial       (dp_partial),
        .dp_partial_valid (dp_partial_valid),
        .abort_en         (abort_en),
        .clear_best       (clear_best),
        .res_valid        (res_valid),
        .res_accept       (res_accept),
        .res_aborted      (res_aborted),
        .res_energy       (res_energy),
        .best_valid       (best_valid),
        .best_energy      (best_energy),
        .best_sigma       (best_sigma),
        .err_unexpected   (err_unexpected)
    );

    typedef struct {
        logic signed [EW-1:0] energy;
        logic                 accept;
        logic                 aborted;
        logic signed [EW-1:0] best_e;
        logic [VS-1:0]        best_s;
    } exp_t;

    typedef struct {
        int                   rel;
        logic signed [EW-1:0] val;
    } pend_t;

    exp_t  sb_q[$];
    pend_t pend_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Responder configuration (written by the stimulus process only)
    int pmode      = 0;
    int delay      = 1;
    bit gnt_toggle = 1'b0;
    bit inject_req = 1'b0;

    // Per-run statistics (written by the responder only)
    int run_grants = 0;
    int max_out    = 0;
    int addr_err   = 0;
    int stab_err   = 0;

    task automatic check(input string name, input logic [VS-1:0] act, input logic [VS-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic signed [EW-1:0] part_val(input int mode, input logic [AW-1:0] addr);
        case (mode)
            0:       return EW'(1);
            1:       return EW'(-1);
            2:       return EW'(0);
            3:       return EW'(addr);
            default: return (addr < AW'(36)) ? EW'(2) : EW'(1);
        endcase
    endfunction

    function automatic exp_t mk_exp(input int en, input bit acc, input bit ab,
                                    input int be, input logic [VS-1:0] bs);
        exp_t e;
        e.energy  = EW'(en);
        e.accept  = acc;
        e.aborted = ab;
        e.best_e  = EW'(be);
        e.best_s  = bs;
        return e;
    endfunction

    // J-memory grant and datapath return model; partials come back in order
    initial begin : responder
        int            k;
        int            out_model;
        logic          pend_ungnt;
        logic [AW-1:0] prev_addr;
        pend_t         p;
        k = 0; out_model = 0; pend_ungnt = 1'b0; prev_addr = '0;
        mem_gnt = 1'b0; dp_partial_valid = 1'b0; dp_partial = '0;
        forever begin
            @(negedge clk);
            k++;
            dp_partial_valid = 1'b0;
            dp_partial       = '0;
            if (!rst_n) begin
                pend_q.delete();
                out_model  = 0;
                pend_ungnt = 1'b0;
                mem_gnt    = 1'b0;
            end else begin
                if (cand_valid && cand_ready) begin
                    run_grants = 0; max_out = 0; addr_err = 0; stab_err = 0;
                end
                if (inject_req) begin
                    dp_partial_valid = 1'b1;
                    dp_partial       = EW'(7);
                end else if (pend_q.size() > 0 && pend_q[0].rel <= k) begin
                    p = pend_q.pop_front();
                    dp_partial_valid = 1'b1;
                    dp_partial       = p.val;
                    out_model--;
                end
                if (pend_ungnt && !(mem_req && mem_addr == prev_addr)) stab_err++;
                mem_gnt = gnt_toggle ? (k % 2 == 0) : 1'b1;
                if (mem_req && mem_gnt) begin
                    if (mem_addr != AW'(run_grants)) addr_err++;
                    p.rel = k + delay;
                    p.val = part_val(pmode, mem_addr);
                    pend_q.push_back(p);
                    run_grants++;
                    out_model++;
                    if (out_model > max_out) max_out = out_model;
                end
                pend_ungnt = mem_req && !mem_gnt;
                prev_addr  = mem_addr;
            end
        end
    end

    // Scoreboard monitor: results checked as they appear, best state one cycle later
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && res_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_result", VS'(1), VS'(0));
                end else begin
                    e = sb_q.pop_front();
                    check("res_energy",  VS'(res_energy),  VS'(e.energy));
                    check("res_accept",  VS'(res_accept),  VS'(e.accept));
                    check("res_aborted", VS'(res_aborted), VS'(e.aborted));
                    @(negedge clk);
                    check("best_valid",  VS'(best_valid),  VS'(1));
                    check("best_energy", VS'(best_energy), VS'(e.best_e));
                    check("best_sigma",  best_sigma,       e.best_s);
                end
            end
        end
    end

    task automatic start_cand(input logic [VS-1:0] sig, input int mode, input int dly,
                              input bit tog, input bit abrt);
        pmode      = mode;
        delay      = dly;
        gnt_toggle = tog;
        abort_en   = abrt;
        @(posedge clk); #1;
        cand_valid = 1'b1;
        cand_sigma = sig;
        @(posedge clk); #1;
        cand_valid = 1'b0;
    endtask

    task automatic run_cand(input logic [VS-1:0] sig, input int mode, input int dly,
                            input bit tog, input bit abrt, input exp_t e, output int lat);
        sb_q.push_back(e);
        start_cand(sig, mode, dly, tog, abrt);
        lat = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            lat++;
            if (res_valid) break;
        end
        if (!res_valid) check("res_timeout", VS'(0), VS'(1));
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        logic [VS-1:0] sa, sb, sc, sd, se, sf, sg, sh;
        int            lat;
        sa = {8{32'hA5A5_0001}};
        sb = {8{32'h5A5A_0002}};
        sc = {8{32'h1234_0003}};
        sd = {8{32'hCAFE_0004}};
        se = {8{32'hBEEF_0005}};
        sf = {8{32'h0F0F_0006}};
        sg = {8{32'hDEAD_0007}};
        sh = {8{32'h7777_0008}};

        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req",     VS'(mem_req),        VS'(0));
        check("rst_mem_addr",    VS'(mem_addr),       VS'(0));
        check("rst_res_valid",   VS'(res_valid),      VS'(0));
        check("rst_best_valid",  VS'(best_valid),     VS'(0));
        check("rst_best_energy", VS'(best_energy),    VS'(0));
        check("rst_dp_sigma",    dp_sigma,            VS'(0));
        check("rst_err",         VS'(err_unexpected), VS'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All +1: first result always accepted
        run_cand(sa, 0, 1, 1'b0, 1'b0, mk_exp(64, 1'b1, 1'b0, 64, sa), lat);
        check("latency_first", VS'(lat),        VS'(66));
        check("grants_first",  VS'(run_grants), VS'(64));
        check("addr_seq_first", VS'(addr_err),  VS'(0));

        // All -1: lower energy replaces best
        run_cand(sb, 1, 1, 1'b0, 1'b0, mk_exp(-64, 1'b1, 1'b0, -64, sb), lat);
        check("grants_second", VS'(run_grants), VS'(64));

        // Zero partials with abort: 0 >= -64 on the first return, two reads issued
        run_cand(sc, 2, 1, 1'b0, 1'b1, mk_exp(0, 1'b0, 1'b1, -64, sb), lat);
        check("grants_abort", VS'(run_grants), VS'(2));
        check("req_after_abort", VS'(mem_req), VS'(0));

        // Toggling grant, 5-cycle return, partial = chunk index: sum 0..63 = 2016
        run_cand(sd, 3, 5, 1'b1, 1'b0, mk_exp(2016, 1'b0, 1'b0, -64, sb), lat);
        check("addr_stable",   VS'(stab_err),        VS'(0));
        check("outstanding_le4", VS'(max_out <= 4),  VS'(1));
        check("addr_seq_toggle", VS'(addr_err),      VS'(0));

        // Full grant with 5-cycle return fills exactly four outstanding reads
        run_cand(se, 0, 5, 1'b0, 1'b0, mk_exp(64, 1'b0, 1'b0, -64, sb), lat);
        check("outstanding_max", VS'(max_out), VS'(4));

        // clear_best in IDLE, then a sum of +100 is accepted even with abort enabled
        @(posedge clk); #1;
        clear_best = 1'b1;
        @(posedge clk); #1;
        clear_best = 1'b0;
        check("clear_best", VS'(best_valid), VS'(0));
        run_cand(sf, 4, 1, 1'b0, 1'b1, mk_exp(100, 1'b1, 1'b0, 100, sf), lat);

        // Partial while nothing outstanding sets the sticky error
        @(posedge clk); #1;
        inject_req = 1'b1;
        @(posedge clk); #1;
        inject_req = 1'b0;
        @(posedge clk); #1;
        check("err_set", VS'(err_unexpected), VS'(1));
        repeat (5) @(posedge clk);
        #1;
        check("err_sticky", VS'(err_unexpected), VS'(1));

        // Reset in the middle of a fetch discards everything
        start_cand(sg, 0, 1, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("mid_rst_mem_req",     VS'(mem_req),        VS'(0));
        check("mid_rst_mem_addr",    VS'(mem_addr),       VS'(0));
        check("mid_rst_res_valid",   VS'(res_valid),      VS'(0));
        check("mid_rst_res_energy",  VS'(res_energy),     VS'(0));
        check("mid_rst_best_valid",  VS'(best_valid),     VS'(0));
        check("mid_rst_best_energy", VS'(best_energy),    VS'(0));
        check("mid_rst_best_sigma",  best_sigma,          VS'(0));
        check("mid_rst_dp_sigma",    dp_sigma,            VS'(0));
        check("mid_rst_err",         VS'(err_unexpected), VS'(0));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_cand(sh, 0, 1, 1'b0, 1'b0, mk_exp(64, 1'b1, 1'b0, 64, sh), lat);
        check("latency_after_rst", VS'(lat), VS'(66));

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", VS'(sb_q.size()), VS'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
